// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
//   Program counter with increment / jump / register-jump / relative branch /
//   conditional branch / call / return modes. Calls and returns use an internal
//   LIFO return-address stack (RAS) with sticky overflow/underflow flags.
//
// Ports
//   clka          in   system clock, every state update on its rising edge
//   reset         in   synchronous active-high reset, wins over everything
//   pc_latch_data in   update enable; 0 stalls PC, RAS and error flags
//   pc_ctl        in   [2:0] next-PC mode select
//   imm           in   [PC_BITS-1:0] jump/call target or signed branch offset
//   sr1_val       in   [PC_BITS-1:0] register jump target
//   cond          in   condition for the conditional branch
//   pc_out        out  [PC_BITS-1:0] current PC (registered)
//   ret_addr      out  [PC_BITS-1:0] top of RAS, 0 when empty
//   stack_empty   out  RAS holds no entries
//   stack_full    out  RAS holds STACK_DEPTH entries
//   stack_err     out  [1:0] sticky flags: bit0 overflow, bit1 underflow
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int                 PC_BITS      = 6,
    parameter int                 STACK_DEPTH  = 4,
    parameter logic [PC_BITS-1:0] RESET_VECTOR = '0
) (
    input  logic               clka,
    input  logic               reset,
    input  logic               pc_latch_data,
    input  logic [2:0]         pc_ctl,
    input  logic [PC_BITS-1:0] imm,
    input  logic [PC_BITS-1:0] sr1_val,
    input  logic               cond,
    output logic [PC_BITS-1:0] pc_out,
    output logic [PC_BITS-1:0] ret_addr,
    output logic               stack_empty,
    output logic               stack_full,
    output logic [1:0]         stack_err
);

    // Count spans 0..STACK_DEPTH inclusive, so it needs one more code point
    // than the entry index does.
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_INC  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JR   = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b011;
    localparam logic [2:0] OP_BRC  = 3'b100;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;
    localparam logic [2:0] OP_HOLD = 3'b111;

    logic [PC_BITS-1:0] pc_q, pc_d;
    logic [PC_BITS-1:0] pc_inc;
    logic [PC_BITS-1:0] pc_rel;
    logic [PC_BITS-1:0] stack_q [STACK_DEPTH];
    logic [PC_BITS-1:0] top_val;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         err_q, err_d;
    logic               push;
    logic               empty, full;
    logic [IDX_W-1:0]   top_idx, push_idx;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(STACK_DEPTH));
    assign top_idx  = IDX_W'(count_q - CNT_W'(1));
    assign push_idx = IDX_W'(count_q);

    assign pc_inc  = pc_q + PC_BITS'(1);
    // Modulo-2^PC_BITS addition of the raw offset is identical to adding the
    // sign-extended offset and truncating, so no explicit extension is needed.
    assign pc_rel  = pc_q + imm;
    assign top_val = empty ? '0 : stack_q[top_idx];

    // Next-state selection
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        err_d   = err_q;
        push    = 1'b0;
        if (pc_latch_data) begin
            case (pc_ctl)
                OP_INC:  pc_d = pc_inc;
                OP_JMP:  pc_d = imm;
                OP_JR:   pc_d = sr1_val;
                OP_BR:   pc_d = pc_rel;
                OP_BRC:  pc_d = cond ? pc_rel : pc_inc;
                OP_CALL: begin
                    // The jump always happens; only the push is dropped on
                    // overflow so existing return addresses survive.
                    pc_d = imm;
                    if (full) begin
                        err_d[0] = 1'b1;
                    end else begin
                        push    = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        pc_d     = pc_inc;
                        err_d[1] = 1'b1;
                    end else begin
                        pc_d    = top_val;
                        count_d = count_q - CNT_W'(1);
                    end
                end
                OP_HOLD: pc_d = pc_q;
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            count_q <= '0;
            err_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Entry storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clka) begin
        if (!reset && push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc_out      = pc_q;
    assign ret_addr    = top_val;
    assign stack_empty = empty;
    assign stack_full  = full;
    assign stack_err   = err_q;

endmodule
